// File: rtl/alu_frame_loader_if.sv
// Byte-stream and ALU load-bus signals of alu_frame_loader.
// The slave modport is the loader itself; master is the byte source / ALU side.
interface alu_frame_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 6
);
    localparam int BUS_WIDTH = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH;

    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic                 o_rx_ready;
    logic [BUS_WIDTH-1:0] o_data_bus;
    logic                 o_load_A;
    logic                 o_load_B;
    logic                 o_load_op;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_data_bus, o_load_A, o_load_B, o_load_op,
               o_busy, o_done, o_error
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_data_bus, o_load_A, o_load_B, o_load_op,
               o_busy, o_done, o_error
    );
endinterface

// File: rtl/alu_frame_loader.sv
// Collects an A/B/OP byte frame and replays it as three strobed loads on a shared bus.
// Define ALU_FRAME_LOADER_CHECKSUM_EN to require a fourth CHK byte equal to A^B^OP.
module alu_frame_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int MODE_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_frame_loader_if.slave io_bus
);
    localparam int BUS_WIDTH = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
    // The checksum covers full bytes, so the upper bits must be kept.
    localparam int A_WIDTH  = 8;
    localparam int B_WIDTH  = 8;
    localparam int OP_WIDTH = 8;
`else
    localparam int A_WIDTH  = DATA_WIDTH;
    localparam int B_WIDTH  = DATA_WIDTH;
    localparam int OP_WIDTH = MODE_WIDTH;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_B,
        S_GET_OP,
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
        S_GET_CHK,
`endif
        S_SET_A,
        S_STB_A,
        S_SET_B,
        S_STB_B,
        S_SET_OP,
        S_STB_OP,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [A_WIDTH-1:0]    r_a;
    logic [B_WIDTH-1:0]    r_b;
    logic [OP_WIDTH-1:0]   r_op;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [BUS_WIDTH-1:0]  r_data_bus;
    logic                  r_error;
    logic                  w_in_get;
    logic                  w_busy;
    logic                  w_rx_ready;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_chk_bad;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_in_get  = 1'b0;
        w_busy    = 1'b0;
        w_chk_bad = 1'b0;
        w_next    = r_state;

        case (r_state)
            S_IDLE:            ;
            S_GET_B, S_GET_OP: w_in_get = 1'b1;
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
            S_GET_CHK:         w_in_get = 1'b1;
`endif
            default:           w_busy = 1'b1;
        endcase

        w_rx_ready = w_in_get || (r_state == S_IDLE);
        w_accept   = io_bus.i_rx_valid && w_rx_ready;
        // An accepted byte on the expiry edge wins over the timeout.
        w_timeout  = w_in_get && !w_accept && (r_cnt == CNT_LAST);
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
        w_chk_bad  = (r_state == S_GET_CHK) && w_accept &&
                     (io_bus.i_rx_data != (r_a ^ r_b ^ r_op));
`endif

        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_GET_B;
            S_GET_B:  if (w_accept) w_next = S_GET_OP;
                      else if (w_timeout) w_next = S_IDLE;
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
            S_GET_OP: if (w_accept) w_next = S_GET_CHK;
                      else if (w_timeout) w_next = S_IDLE;
            S_GET_CHK: if (w_accept) w_next = w_chk_bad ? S_IDLE : S_SET_A;
                       else if (w_timeout) w_next = S_IDLE;
`else
            S_GET_OP: if (w_accept) w_next = S_SET_A;
                      else if (w_timeout) w_next = S_IDLE;
`endif
            S_SET_A:  w_next = S_STB_A;
            S_STB_A:  w_next = S_SET_B;
            S_SET_B:  w_next = S_STB_B;
            S_STB_B:  w_next = S_SET_OP;
            S_SET_OP: w_next = S_STB_OP;
            S_STB_OP: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_error <= w_timeout || w_chk_bad;
            if (!w_in_get || w_accept || w_timeout) r_cnt <= '0;
            else                                    r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE:   r_a  <= io_bus.i_rx_data[A_WIDTH-1:0];
                S_GET_B:  r_b  <= io_bus.i_rx_data[B_WIDTH-1:0];
                S_GET_OP: r_op <= io_bus.i_rx_data[OP_WIDTH-1:0];
                default:  ;
            endcase
        end
    end

    // The bus is loaded on entry to each SET_x and otherwise holds, which keeps it stable
    // around every strobe and preserves the last item after DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_bus <= '0;
        end else begin
            case (w_next)
                S_SET_A:  r_data_bus <= BUS_WIDTH'(r_a[DATA_WIDTH-1:0]);
                S_SET_B:  r_data_bus <= BUS_WIDTH'(r_b[DATA_WIDTH-1:0]);
                S_SET_OP: r_data_bus <= BUS_WIDTH'(r_op[MODE_WIDTH-1:0]);
                default:  ;
            endcase
        end
    end

    assign io_bus.o_rx_ready = w_rx_ready;
    assign io_bus.o_data_bus = r_data_bus;
    assign io_bus.o_load_A   = (r_state == S_STB_A);
    assign io_bus.o_load_B   = (r_state == S_STB_B);
    assign io_bus.o_load_op  = (r_state == S_STB_OP);
    assign io_bus.o_busy     = w_busy;
    assign io_bus.o_done     = (r_state == S_DONE);
    assign io_bus.o_error    = r_error;
endmodule

// File: tb/tb_alu_frame_loader.sv
// Scoreboard bench for alu_frame_loader: stimulus pushes timed expected events,
// a negedge monitor pops and compares every strobe / done / error it observes.
module tb_alu_frame_loader;
    localparam int DW = 8;
    localparam int MW = 6;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_frame_loader_if #(.DATA_WIDTH(DW), .MODE_WIDTH(MW)) bus ();

    alu_frame_loader #(.DATA_WIDTH(DW), .MODE_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    typedef enum int {EV_A, EV_B, EV_OP, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;

    // cyc holds the index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [7:0] d, input int t);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.t    = t;
        sb_q.push_back(e);
    endtask

    // Present one byte from a negedge and hold it until accepted; n = accepting edge index.
    task automatic send_byte(input logic [7:0] d, output int n);
        logic rdy;
        int   edge_idx;
        n = -1;
        @(negedge clk);
        bus.i_rx_data  = d;
        bus.i_rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy      = bus.o_rx_ready;
            edge_idx = cyc + 1;
            @(posedge clk);
            if (rdy) begin
                n = edge_idx;
                break;
            end
            @(negedge clk);
        end
        if (n < 0) check("byte_accept_within_budget", 32'd0, 32'd1);
    endtask

    // Walk to the negedge whose preceding edge index is target, holding i_rx_valid low.
    task automatic wait_cyc(input int target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.i_rx_valid = 1'b0;
            if (cyc == target) break;
        end
        check("wait_target_reached", cyc, target);
    endtask

    task automatic push_frame(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_bus);
        push(EV_A,    a,      n + 2);
        push(EV_B,    b,      n + 4);
        push(EV_OP,   op_bus, n + 6);
        push(EV_DONE, 8'h00,  n + 7);
    endtask

    // Send the remaining frame bytes after A; returns the edge of the last byte.
    task automatic send_tail(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, output int n);
        int nb;
        send_byte(b, nb);
        send_byte(op, n);
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
        send_byte(a ^ b ^ op, n);
`else
        if (a == 8'hxx) n = -1;
`endif
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] op_bus, output int n);
        int na;
        send_byte(a, na);
        send_tail(a, b, op, n);
        push_frame(n, a, b, op_bus);
    endtask

    // Monitor: every observed output event must match the head of the scoreboard.
    initial begin
        logic [7:0] prev_bus;
        logic       la, lb, lop, dn, er;
        ev_kind_t   kind;
        ev_t        e;
        int         t;
        prev_bus = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                la  = bus.o_load_A;
                lb  = bus.o_load_B;
                lop = bus.o_load_op;
                dn  = bus.o_done;
                er  = bus.o_error;
                t   = cyc + 1;
                if (la | lb | lop | dn | er) begin
                    check("single_output_event", $countones({la, lb, lop, dn, er}), 1);
                    kind = la ? EV_A : lb ? EV_B : lop ? EV_OP : dn ? EV_DONE : EV_ERR;
                    check("event_was_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("event_kind", kind, e.kind);
                        check("event_edge", t, e.t);
                        if (la | lb | lop) begin
                            check("strobe_bus_value", bus.o_data_bus, e.data);
                            check("bus_stable_before_strobe", bus.o_data_bus, prev_bus);
                        end
                    end
                end
                prev_bus = bus.o_data_bus;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n0, n1, na;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;

        // Reset state
        #12;
        check("reset_rx_ready", bus.o_rx_ready, 1'b1);
        check("reset_data_bus", bus.o_data_bus, 8'h00);
        check("reset_controls", {bus.o_load_A, bus.o_load_B, bus.o_load_op,
                                 bus.o_busy, bus.o_done, bus.o_error}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + 2);

        // Back-to-back frame, timing of busy / ready around the load sequence
        send_frame(8'h05, 8'hFB, 8'h20, 8'h20, n);
        wait_cyc(n);
        check("busy_in_set_a", bus.o_busy, 1'b1);
        check("ready_low_in_set_a", bus.o_rx_ready, 1'b0);
        wait_cyc(n + 7);
        check("ready_back_in_idle", bus.o_rx_ready, 1'b1);
        check("busy_clear_in_idle", bus.o_busy, 1'b0);
        check("bus_holds_after_done", bus.o_data_bus, 8'h20);

        // Opcode upper bits dropped: 0xE7 -> 0x27
        send_frame(8'h3C, 8'hA5, 8'hE7, 8'h27, n);
        wait_cyc(n + 8);

        // Timeout after a lone A byte, then a normal frame
        send_byte(8'h11, n0);
        push(EV_ERR, 8'h00, n0 + 17);
        wait_cyc(n0 + 20);
        send_frame(8'h01, 8'h02, 8'h03, 8'h03, n);
        wait_cyc(n + 8);

        // Byte arriving exactly on the timeout edge is accepted, no error
        send_byte(8'h5A, n0);
        wait_cyc(n0 + 14);
        send_byte(8'hC3, n1);
        check("byte_on_timeout_edge", n1, n0 + 16);
        send_byte(8'h81, n);
`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
        send_byte(8'h5A ^ 8'hC3 ^ 8'h81, n);
`endif
        push_frame(n, 8'h5A, 8'hC3, 8'h01);
        wait_cyc(n + 8);

        // Held valid during loading is not consumed until IDLE
        send_frame(8'h05, 8'hFB, 8'h20, 8'h20, n);
        send_byte(8'h44, n1);
        check("held_byte_accept_edge", n1, n + 8);
        send_tail(8'h44, 8'h55, 8'h66, n);
        push_frame(n, 8'h44, 8'h55, 8'h26);
        wait_cyc(n + 8);

        // Reset asserted during STB_B
        send_byte(8'h0A, na);
        send_tail(8'h0A, 8'h0B, 8'h0C, n);
        push(EV_A, 8'h0A, n + 2);
        wait_cyc(n + 2);
        @(posedge clk);
        #2;
        check("stb_b_active_before_reset", bus.o_load_B, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_load_b", bus.o_load_B, 1'b0);
        check("reset_drops_busy", bus.o_busy, 1'b0);
        check("reset_clears_bus", bus.o_data_bus, 8'h00);
        check("reset_ready_high", bus.o_rx_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + 12);
        send_frame(8'h0F, 8'hF0, 8'h3F, 8'h3F, n);
        wait_cyc(n + 8);

`ifdef ALU_FRAME_LOADER_CHECKSUM_EN
        // Explicit good and bad checksum frames
        send_byte(8'h05, na);
        send_byte(8'hFB, na);
        send_byte(8'h20, na);
        send_byte(8'hDE, n);
        push_frame(n, 8'h05, 8'hFB, 8'h20);
        wait_cyc(n + 8);
        send_byte(8'h05, na);
        send_byte(8'hFB, na);
        send_byte(8'h20, na);
        send_byte(8'hDF, n);
        push(EV_ERR, 8'h00, n + 1);
        wait_cyc(n + 10);
`endif

        wait_cyc(cyc + 5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_frame_loader.md
ALU_FRAME_LOADER -- requirements
Module: alu_frame_loader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, operand width (1..8); MODE_WIDTH, 6, opcode width (1..8); TIMEOUT_CYCLES, 16, inter-byte timeout in clocks (>=2).
REQ-002 Localparam BUS_WIDTH SHALL equal max(DATA_WIDTH, MODE_WIDTH).
REQ-003 Ports, one per line:
  i_clk  in  1  single clock, rising edge.
  i_rst_n  in  1  asynchronous, active-low reset.
  i_rx_data  in  8  incoming frame byte.
  i_rx_valid  in  1  i_rx_data valid.
  o_rx_ready  out  1  block can accept a byte.
  o_data_bus  out  BUS_WIDTH  operand/opcode bus to the ALU control unit.
  o_load_A  out  1  load strobe, operand A.
  o_load_B  out  1  load strobe, operand B.
  o_load_op  out  1  load strobe, opcode.
  o_busy  out  1  frame accepted, loads in progress.
  o_done  out  1  one-cycle pulse, all loads issued.
  o_error  out  1  one-cycle pulse, frame discarded.
REQ-004 Clocking/reset SHALL be one clock i_clk; reset i_rst_n asynchronous, active-low.

Function
REQ-005 Byte transfer SHALL occur on a rising edge with i_rx_valid=1 and o_rx_ready=1; no other edge consumes a byte.
REQ-006 Frame SHALL be A, B, OP bytes in order (plus CHK when the Configuration macro is defined).
REQ-007 States SHALL be: IDLE(wait A), GET_B, GET_OP, [GET_CHK], SET_A, STB_A, SET_B, STB_B, SET_OP, STB_OP, DONE.
REQ-008 o_rx_ready SHALL be decoded from state: 1 in IDLE/GET_*, 0 elsewhere.
REQ-009 Collected bytes SHALL be held in internal registers; no strobe is issued until the frame is complete (and valid).
REQ-010 With last byte accepted at edge N: SET_A at N+1, STB_A N+2, SET_B N+3, STB_B N+4, SET_OP N+5, STB_OP N+6, DONE N+7, IDLE N+8.
REQ-011 In SET_x and STB_x, o_data_bus SHALL carry the item zero-extended to BUS_WIDTH: A[DATA_WIDTH-1:0], B[DATA_WIDTH-1:0], OP[MODE_WIDTH-1:0]; upper byte bits dropped.
REQ-012 Each strobe SHALL be high only in its STB_x state (exactly one cycle); o_data_bus SHALL be stable one cycle before, during, and at the falling edge of the strobe.
REQ-013 At most one of o_load_A/o_load_B/o_load_op SHALL be high in any cycle.
REQ-014 o_busy SHALL be 1 in SET_A..DONE; o_done SHALL be 1 only in DONE.
REQ-015 o_data_bus SHALL hold its last value after DONE until the next SET_A.
REQ-016 Timeout counter SHALL clear on every accepted byte and in IDLE; in GET_* when it reaches TIMEOUT_CYCLES-1 without a byte, next edge SHALL pulse o_error, discard the partial frame, return to IDLE.
REQ-017 A byte accepted on the timeout edge SHALL take priority over timeout.
REQ-018 i_rx_valid while o_rx_ready=0 SHALL be ignored; source holds the byte until accepted.

Reset
REQ-019 Reset assertion SHALL immediately force IDLE, o_data_bus=0, all strobes/o_busy/o_done/o_error=0, timeout counter 0, byte registers 0.
REQ-020 Reset mid-frame or mid-load SHALL discard the frame; no strobe fires after release until a new complete frame.
REQ-021 o_rx_ready SHALL read 1 during and after reset (IDLE decode).

Configuration
REQ-022 Macro ALU_FRAME_LOADER_CHECKSUM_EN defined: GET_CHK state present; frame is 4 bytes; CHK must equal A^B^OP (full 8 bits).
REQ-023 Macro defined, CHK mismatch: no strobes, o_error pulse the cycle after CHK accepted, return to IDLE; match: SET_A follows as REQ-010.
REQ-024 Macro undefined: GET_CHK absent; OP byte completes the frame; o_error arises only from timeout.

Verification
REQ-025 No macro, bytes 0x05,0xFB,0x20 back-to-back -> strobes A/B/op at N+2/N+4/N+6 with bus 0x05/0xFB/0x20, o_done at N+7, o_rx_ready=1 at N+8.
REQ-026 OP byte 0xE7 -> o_data_bus=0x27 during o_load_op.
REQ-027 Byte 0x11 then no valid for 16 cycles -> one o_error pulse, no strobes; following frame 0x01,0x02,0x03 loads normally.
REQ-028 Macro defined: 0x05,0xFB,0x20,0xDE -> three strobes, o_done; 0x05,0xFB,0x20,0xDF -> o_error, no strobes.
REQ-029 i_rst_n low during STB_B -> o_load_B and o_busy drop without a clock edge; o_load_op never fires; new frame after release succeeds.
REQ-030 i_rx_valid=1 with 0x44 held through N+1..N+7 -> not consumed; accepted at edge N+8 as byte A.
